// File: rtl/avalon_timer_host_if.sv
// Avalon-MM signal bundle between the timer host (master) and the
// interval-timer s1 port (slave).
interface avalon_timer_host_if;
   logic [3:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [15:0] avm_writedata;
   logic [15:0] avm_readdata;

   modport master (
      output avm_address, avm_chipselect, avm_write_n, avm_writedata,
      input  avm_readdata
   );

   modport slave (
      input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
      output avm_readdata
   );
endinterface

// File: rtl/avalon_timer_host.sv
// Avalon-MM initiator that programs, services and snapshots a 16-bit interval
// timer so fabric logic can pace frames without a CPU.
module avalon_timer_host #(
   parameter int unsigned TICK_W = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                stop,
   input  logic                snap_req,
   input  logic [63:0]         period_in,
   input  logic                continuous,
   input  logic                irq,
   avalon_timer_host_if.master avm,
   output logic                busy,
   output logic                running,
   output logic                tick,
   output logic [TICK_W-1:0]   tick_count,
   output logic                snap_valid,
   output logic [63:0]         snap_value
);

   typedef enum logic [2:0] {
      StIdle, StCfg, StRun, StAck, StStopW, StSnapW, StSnapR
   } state_e;

   state_e              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                snap_ret_q, snap_ret_d;
   logic                take_start;
   logic [63:0]         per_q, per_src;
   logic                cont_q, cont_src;
   logic [47:0]         shadow_q;
   logic [3:0]          addr_q, addr_d;
   logic                cs_q, cs_d;
   logic                wn_q, wn_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                busy_q, running_q, tick_q, snap_valid_q;
   logic [TICK_W-1:0]   tick_count_q;
   logic [63:0]         snap_value_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      snap_ret_d = snap_ret_q;
      take_start = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               take_start = 1'b1;
               state_d    = StCfg;
            end else if (snap_req) begin
               snap_ret_d = 1'b0;
               state_d    = StSnapW;
            end
         end
         StCfg: begin
            if (cnt_q == 3'd4) state_d = StRun;
            else               cnt_d   = cnt_q + 3'd1;
         end
         StRun: begin
            if (irq) begin
               state_d = StAck;
            end else if (stop) begin
               state_d = StStopW;
            end else if (start) begin
               take_start = 1'b1;
               state_d    = StCfg;
            end else if (snap_req) begin
               snap_ret_d = 1'b1;
               state_d    = StSnapW;
            end
         end
         StAck:   state_d = cont_q ? StRun : StIdle;
         StStopW: state_d = StIdle;
         StSnapW: state_d = StSnapR;
         StSnapR: begin
            if (cnt_q == 3'd4) state_d = snap_ret_q ? StRun : StIdle;
            else               cnt_d   = cnt_q + 3'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   // The first CFG write goes out on the same edge that latches the inputs.
   assign per_src  = take_start ? period_in  : per_q;
   assign cont_src = take_start ? continuous : cont_q;

   always_comb begin
      addr_d  = '0;
      cs_d    = 1'b0;
      wn_d    = 1'b1;
      wdata_d = '0;
      case (state_d)
         StCfg: begin
            cs_d = 1'b1;
            wn_d = 1'b0;
            case (cnt_d)
               3'd0:    begin addr_d = 4'd2; wdata_d = per_src[15:0];  end
               3'd1:    begin addr_d = 4'd3; wdata_d = per_src[31:16]; end
               3'd2:    begin addr_d = 4'd4; wdata_d = per_src[47:32]; end
               3'd3:    begin addr_d = 4'd5; wdata_d = per_src[63:48]; end
               default: begin addr_d = 4'd1; wdata_d = {13'b0, 1'b1, cont_src, 1'b1}; end
            endcase
         end
         StAck: begin
            cs_d = 1'b1;
            wn_d = 1'b0;
         end
         StStopW: begin
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            addr_d  = 4'd1;
            wdata_d = 16'h0008;
         end
         StSnapW: begin
            cs_d   = 1'b1;
            wn_d   = 1'b0;
            addr_d = 4'd6;
         end
         StSnapR: begin
            cs_d   = 1'b1;
            addr_d = (cnt_d == 3'd4) ? 4'd0 : 4'd6 + {1'b0, cnt_d};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         snap_ret_q   <= 1'b0;
         per_q        <= '0;
         cont_q       <= 1'b0;
         shadow_q     <= '0;
         addr_q       <= '0;
         cs_q         <= 1'b0;
         wn_q         <= 1'b1;
         wdata_q      <= '0;
         busy_q       <= 1'b0;
         running_q    <= 1'b0;
         tick_q       <= 1'b0;
         tick_count_q <= '0;
         snap_valid_q <= 1'b0;
         snap_value_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         snap_ret_q <= snap_ret_d;
         addr_q     <= addr_d;
         cs_q       <= cs_d;
         wn_q       <= wn_d;
         wdata_q    <= wdata_d;
         busy_q     <= (state_d != StIdle) && (state_d != StRun);
         running_q  <= (state_d == StRun);
         tick_q     <= (state_d == StAck);
         if (take_start) begin
            per_q        <= period_in;
            cont_q       <= continuous;
            tick_count_q <= '0;
         end else if (state_q == StAck) begin
            tick_count_q <= tick_count_q + TICK_W'(1);
         end
         // Read data lags the address by one cycle; publish all 64 bits at once.
         snap_valid_q <= 1'b0;
         if (state_q == StSnapR) begin
            case (cnt_q)
               3'd1: shadow_q[15:0]  <= avm.avm_readdata;
               3'd2: shadow_q[31:16] <= avm.avm_readdata;
               3'd3: shadow_q[47:32] <= avm.avm_readdata;
               3'd4: begin
                  snap_value_q <= {avm.avm_readdata, shadow_q};
                  snap_valid_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign avm.avm_address    = addr_q;
   assign avm.avm_chipselect = cs_q;
   assign avm.avm_write_n    = wn_q;
   assign avm.avm_writedata  = wdata_q;
   assign busy               = busy_q;
   assign running            = running_q;
   assign tick               = tick_q;
   assign tick_count         = tick_count_q;
   assign snap_valid         = snap_valid_q;
   assign snap_value         = snap_value_q;

endmodule

// File: tb/tb_avalon_timer_host.sv
// Bench for avalon_timer_host: interval-timer peripheral model, a queue-based
// transaction reference checked every cycle, table-driven and directed tests.
module tb_avalon_timer_host;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0, stop = 1'b0, snap_req = 1'b0;
   logic [63:0] period_in = '0;
   logic        continuous = 1'b0;
   logic        irq;
   logic        busy, running, tick, snap_valid;
   logic [31:0] tick_count;
   logic [63:0] snap_value;

   int vectors = 0;
   int miscompares = 0;
   int cyc_n = 0;
   int n_tick = 0;

   avalon_timer_host_if bus ();

   avalon_timer_host #(.TICK_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .stop       (stop),
      .snap_req   (snap_req),
      .period_in  (period_in),
      .continuous (continuous),
      .irq        (irq),
      .avm        (bus),
      .busy       (busy),
      .running    (running),
      .tick       (tick),
      .tick_count (tick_count),
      .snap_valid (snap_valid),
      .snap_value (snap_value)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- interval-timer peripheral model ----------------
   logic [63:0] t_per, t_cnt, t_snap;
   logic        t_to, t_ito, t_cont, t_run;
   logic [15:0] t_rd;
   logic        irq_force = 1'b0, force_snap = 1'b0;
   logic [63:0] force_snap_val = '0;
   int          t_timeouts;
   logic        t_wr, t_wr_ctrl;

   assign irq               = (t_to & t_ito) | irq_force;
   assign bus.avm_readdata  = t_rd;
   assign t_wr              = bus.avm_chipselect & ~bus.avm_write_n;
   assign t_wr_ctrl         = t_wr && (bus.avm_address == 4'd1);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t_per <= '0; t_cnt <= '0; t_snap <= '0; t_rd <= '0;
         t_to <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0; t_run <= 1'b0;
         t_timeouts <= 0;
      end else begin
         if (t_wr) begin
            case (bus.avm_address)
               4'd0: t_to <= 1'b0;
               4'd1: begin
                  t_ito  <= bus.avm_writedata[0];
                  t_cont <= bus.avm_writedata[1];
                  if (bus.avm_writedata[3]) t_run <= 1'b0;
                  else if (bus.avm_writedata[2]) begin
                     t_run <= 1'b1;
                     t_cnt <= t_per;
                  end
               end
               4'd2: t_per[15:0]  <= bus.avm_writedata;
               4'd3: t_per[31:16] <= bus.avm_writedata;
               4'd4: t_per[47:32] <= bus.avm_writedata;
               4'd5: t_per[63:48] <= bus.avm_writedata;
               4'd6: t_snap <= force_snap ? force_snap_val : t_cnt;
               default: ;
            endcase
         end
         if (t_run && !t_wr_ctrl) begin
            if (t_cnt == 64'd0) begin
               t_to       <= 1'b1;
               t_timeouts <= t_timeouts + 1;
               t_cnt      <= t_per;
               if (!t_cont) t_run <= 1'b0;
            end else begin
               t_cnt <= t_cnt - 64'd1;
            end
         end
         case (bus.avm_address)
            4'd0:    t_rd <= {14'b0, t_run, t_to};
            4'd6:    t_rd <= t_snap[15:0];
            4'd7:    t_rd <= t_snap[31:16];
            4'd8:    t_rd <= t_snap[47:32];
            4'd9:    t_rd <= t_snap[63:48];
            default: t_rd <= '0;
         endcase
      end
   end

   // ---------------- transaction-level reference of the host ----------------
   typedef struct packed {
      logic        cs;
      logic        wn;
      logic [3:0]  addr;
      logic [15:0] data;
      logic [1:0]  kind;   // 0 plain, 1 timeout ack, 2 last snapshot read
   } bus_t;

   bus_t        exp_q[$];
   bus_t        cur;
   logic        m_run = 1'b0, m_cont = 1'b0, m_sv = 1'b0;
   logic [31:0] m_ticks = '0;
   logic [63:0] m_snap = '0;

   function automatic bus_t mk(logic cs, logic wn, logic [3:0] a, logic [15:0] d,
                               logic [1:0] k);
      bus_t b;
      b.cs = cs; b.wn = wn; b.addr = a; b.data = d; b.kind = k;
      return b;
   endfunction

   task automatic m_accept();
      logic [63:0] p;
      p       = period_in;
      m_run   = 1'b1;
      m_cont  = continuous;
      m_ticks = '0;
      exp_q.push_back(mk(1'b1, 1'b0, 4'd2, p[15:0], 2'd0));
      exp_q.push_back(mk(1'b1, 1'b0, 4'd3, p[31:16], 2'd0));
      exp_q.push_back(mk(1'b1, 1'b0, 4'd4, p[47:32], 2'd0));
      exp_q.push_back(mk(1'b1, 1'b0, 4'd5, p[63:48], 2'd0));
      exp_q.push_back(mk(1'b1, 1'b0, 4'd1, continuous ? 16'h0007 : 16'h0005, 2'd0));
   endtask

   task automatic m_snapshot();
      exp_q.push_back(mk(1'b1, 1'b0, 4'd6, 16'h0000, 2'd0));
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b1, 1'b1, 4'd6 + 4'(k), 16'h0000, 2'd0));
      exp_q.push_back(mk(1'b1, 1'b1, 4'd0, 16'h0000, 2'd2));
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         m_run = 1'b0; m_cont = 1'b0; m_sv = 1'b0; m_ticks = '0; m_snap = '0;
      end
      cur = (exp_q.size() > 0) ? exp_q[0] : mk(1'b0, 1'b1, 4'd0, 16'h0000, 2'd0);
      chk("cyc_cs",      {63'b0, bus.avm_chipselect}, {63'b0, cur.cs});
      chk("cyc_write_n", {63'b0, bus.avm_write_n},    {63'b0, cur.wn});
      chk("cyc_addr",    {60'b0, bus.avm_address},    {60'b0, cur.addr});
      chk("cyc_wdata",   {48'b0, bus.avm_writedata},  {48'b0, cur.data});
      chk("cyc_busy",    {63'b0, busy},    {63'b0, exp_q.size() > 0});
      chk("cyc_running", {63'b0, running}, {63'b0, (exp_q.size() == 0) && m_run});
      chk("cyc_tick",    {63'b0, tick},    {63'b0, cur.kind == 2'd1});
      chk("cyc_tick_count", {32'b0, tick_count}, {32'b0, m_ticks});
      chk("cyc_snap_valid", {63'b0, snap_valid}, {63'b0, m_sv});
      chk("cyc_snap_value", snap_value, m_snap);
      if (reset_n) begin
         m_sv = 1'b0;
         if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            if (cur.kind == 2'd1) m_ticks = m_ticks + 32'd1;
            if (cur.kind == 2'd2) begin
               m_sv   = 1'b1;
               m_snap = t_snap;
            end
         end else if (!m_run) begin
            if (start)         m_accept();
            else if (snap_req) m_snapshot();
         end else if (irq) begin
            exp_q.push_back(mk(1'b1, 1'b0, 4'd0, 16'h0000, 2'd1));
            if (!m_cont) m_run = 1'b0;
         end else if (stop) begin
            exp_q.push_back(mk(1'b1, 1'b0, 4'd1, 16'h0008, 2'd0));
            m_run = 1'b0;
         end else if (start) begin
            m_accept();
         end else if (snap_req) begin
            m_snapshot();
         end
      end
   end

   // ---------------- bus write log and tick counter ----------------
   typedef struct {
      int          cyc;
      logic [3:0]  addr;
      logic [15:0] data;
   } wlog_t;
   wlog_t wlog[$];

   always @(negedge clk) begin
      if (reset_n && bus.avm_chipselect && !bus.avm_write_n)
         wlog.push_back('{cyc_n, bus.avm_address, bus.avm_writedata});
      if (reset_n && tick) n_tick++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; cyc(1); stop = 1'b0; cyc(3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [63:0] period;
      logic        cont;
      logic [15:0] ctrl;
   } cfg_vec_t;

   initial begin
      cfg_vec_t    tbl[4];
      int          exp_addr[5];
      logic [15:0] exp_data[5];
      logic [63:0] p;
      int          lat, nsv;
      logic [31:0] tc0;

      tbl[0] = '{64'h0000_0000_0000_0031, 1'b1, 16'h0007};
      tbl[1] = '{64'hDEAD_BEEF_0123_4567, 1'b1, 16'h0007};
      tbl[2] = '{64'h0000_0001_0000_0000, 1'b0, 16'h0005};
      tbl[3] = '{64'hFFFF_0000_FFFF_0001, 1'b0, 16'h0005};
      exp_addr = '{2, 3, 4, 5, 1};

      cyc(3);
      reset_n = 1'b1;
      cyc(2);
      chk("rst_cs",         {63'b0, bus.avm_chipselect}, 64'd0);
      chk("rst_write_n",    {63'b0, bus.avm_write_n},    64'd1);
      chk("rst_running",    {63'b0, running},            64'd0);
      chk("rst_tick_count", {32'b0, tick_count},         64'd0);

      // Table: programming sequence for several periods and modes
      for (int i = 0; i < 4; i++) begin
         wlog.delete();
         p          = tbl[i].period;
         period_in  = p;
         continuous = tbl[i].cont;
         start = 1'b1; cyc(1); start = 1'b0;
         cyc(6);
         exp_data = '{p[15:0], p[31:16], p[47:32], p[63:48], tbl[i].ctrl};
         chk("tbl_nwrites", 64'(wlog.size()), 64'd5);
         if (wlog.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
               chk("tbl_addr", {60'b0, wlog[k].addr}, 64'(exp_addr[k]));
               chk("tbl_data", {48'b0, wlog[k].data}, {48'b0, exp_data[k]});
               chk("tbl_consecutive", 64'(wlog[k].cyc - wlog[0].cyc), 64'(k));
            end
         end
         chk("tbl_running", {63'b0, running}, 64'd1);
         pulse_stop();
         chk("tbl_stopped", {63'b0, running}, 64'd0);
      end

      // Continuous period 0x31: ten serviced timeouts in ~510 clocks
      period_in = 64'h31; continuous = 1'b1;
      start = 1'b1; cyc(1); start = 1'b0;
      n_tick = 0;
      cyc(6);
      cyc(510);
      chk("cont_tick_count", {32'b0, tick_count}, 64'd10);
      chk("cont_tick_pulses", 64'(n_tick), 64'd10);
      pulse_stop();

      // One-shot period 9
      wlog.delete();
      period_in = 64'd9; continuous = 1'b0;
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(30);
      chk("oneshot_nwrites", 64'(wlog.size()), 64'd6);
      if (wlog.size() == 6) begin
         chk("oneshot_ctrl", {48'b0, wlog[4].data}, 64'h0005);
         chk("oneshot_ack_addr", {60'b0, wlog[5].addr}, 64'd0);
      end
      chk("oneshot_running", {63'b0, running}, 64'd0);
      chk("oneshot_tick_count", {32'b0, tick_count}, 64'd1);
      wlog.delete();
      cyc(30);
      chk("oneshot_quiet", 64'(wlog.size()), 64'd0);

      // Snapshot during RUN with a planted counter value
      period_in = 64'h1_0000; continuous = 1'b1;
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(8);
      force_snap = 1'b1; force_snap_val = 64'h1234_5678_9ABC_DEF0;
      snap_req = 1'b1; cyc(1); snap_req = 1'b0;
      lat = -1; nsv = 0;
      for (int k = 1; k <= 20; k++) begin
         if (snap_valid) begin
            nsv++;
            if (lat < 0) lat = k;
         end
         cyc(1);
      end
      force_snap = 1'b0;
      chk("snap_latency", 64'(lat), 64'd7);
      chk("snap_pulses", 64'(nsv), 64'd1);
      chk("snap_value", snap_value, 64'h1234_5678_9ABC_DEF0);
      chk("snap_back_to_run", {63'b0, running}, 64'd1);

      // irq and stop together: ack wins, stop dropped
      tc0 = tick_count;
      irq_force = 1'b1; stop = 1'b1; cyc(1); irq_force = 1'b0; stop = 1'b0;
      chk("irqstop_tick", {63'b0, tick}, 64'd1);
      chk("irqstop_ack_addr", {60'b0, bus.avm_address}, 64'd0);
      cyc(3);
      chk("irqstop_running", {63'b0, running}, 64'd1);
      chk("irqstop_tick_count", {32'b0, tick_count}, {32'b0, tc0 + 32'd1});
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("stop_addr", {60'b0, bus.avm_address}, 64'd1);
      chk("stop_data", {48'b0, bus.avm_writedata}, 64'h0008);
      cyc(2);
      chk("stop_running", {63'b0, running}, 64'd0);

      // Asynchronous reset in CFG cycle 2
      period_in = 64'h31; continuous = 1'b1;
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(2);
      chk("pre_reset_cs", {63'b0, bus.avm_chipselect}, 64'd1);
      reset_n = 1'b0;
      #1;
      chk("areset_cs", {63'b0, bus.avm_chipselect}, 64'd0);
      chk("areset_write_n", {63'b0, bus.avm_write_n}, 64'd1);
      chk("areset_tick_count", {32'b0, tick_count}, 64'd0);
      chk("areset_busy", {63'b0, busy}, 64'd0);
      cyc(2);
      reset_n = 1'b1;
      wlog.delete();
      cyc(20);
      chk("post_reset_quiet", 64'(wlog.size()), 64'd0);
      chk("post_reset_running", {63'b0, running}, 64'd0);

      // Randomized requests against the reference, every cycle checked
      for (int i = 0; i < 3000; i++) begin
         start      = ($urandom_range(0, 99) < 3);
         stop       = ($urandom_range(0, 99) < 4);
         snap_req   = ($urandom_range(0, 99) < 4);
         period_in  = 64'($urandom_range(2, 60));
         continuous = $urandom_range(0, 1) == 1;
         cyc(1);
      end
      start = 1'b0; stop = 1'b0; snap_req = 1'b0;
      cyc(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/avalon_timer_host.md
Name: avalon_timer_host

Overview:
- Avalon-MM initiator that drives the 16-bit interval-timer peripheral's s1 slave port.
- Programs the 64-bit period and the control word, services the timer IRQ by clearing status, and counts timeouts.
- Takes and reads back counter snapshots, and issues stop commands.
- Sits between fabric control logic (game/VGA frame pacing) and the timer, so the timer runs without a CPU.

Parameters:
TICK_W, 32, width of timeout counter tick_count (wraps modulo 2^TICK_W)

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
start  in  1  pulse: latch period_in/continuous, program timer, start it
stop  in  1  pulse: stop the timer
snap_req  in  1  pulse: snapshot the counter and read it back
period_in  in  64  timer period value (counts period_in+1 clocks per timeout)
continuous  in  1  1 = continuous mode, 0 = one-shot
irq  in  1  timer interrupt (level, held until status cleared)
avm_address  out  4  timer register word address
avm_chipselect  out  1  bus select
avm_write_n  out  1  active-low write strobe
avm_writedata  out  16  write data
avm_readdata  in  16  read data, valid one cycle after address presented
busy  out  1  high in any state other than IDLE/RUN
running  out  1  high in RUN
tick  out  1  one-cycle pulse per serviced timeout
tick_count  out  TICK_W  serviced timeouts since last start
snap_valid  out  1  one-cycle pulse when snap_value is updated
snap_value  out  64  last snapshot read back

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - busy=0, running=0, tick=0, tick_count=0, snap_valid=0, snap_value=0.
- Idle bus: chipselect=0, write_n=1 in IDLE and RUN. No waitrequest: every write completes in its cycle.
- States: IDLE, CFG, RUN, ACK, STOPW, SNAPW, SNAPR.
- IDLE:
  - Priority start > snap_req; stop is ignored.
  - start: latch period_in to per_q and continuous to cont_q, clear tick_count, go to CFG.
- CFG: 5 consecutive write cycles, then RUN.
  - addr 2 = per_q[15:0], addr 3 = per_q[31:16], addr 4 = per_q[47:32], addr 5 = per_q[63:48].
  - addr 1 = {12'b0, 1'b0, 1'b1, cont_q, 1'b1}, i.e. 0x0007 for continuous, 0x0005 for one-shot.
- RUN:
  - Priority irq > stop > start > snap_req.
  - irq: go to ACK.
  - stop: go to STOPW.
  - start: latch inputs, clear tick_count, go to CFG (reprogram mid-run).
  - snap_req: go to SNAPW.
- ACK:
  - One write cycle to addr 0, data 0x0000.
  - tick=1 this cycle; tick_count increments at the end of the cycle.
  - Next state is RUN if cont_q=1, else IDLE.
  - irq is low by the next cycle, so there is no double count.
- STOPW: one write to addr 1, data 0x0008; then IDLE.
- SNAPW: one write to addr 6, data 0x0000 (snapshot strobe); then SNAPR.
- SNAPR: 5 cycles, chipselect=1, write_n=1.
  - Cycles 0–3 present address 6, 7, 8, 9 in turn; cycle 4 presents address 0.
  - avm_readdata captured on cycles 1–4 into snap_value[15:0], [31:16], [47:32], [63:48].
  - snap_value is not updated until all 4 halfwords are captured: assemble in a shadow register, transfer at the end of cycle 4.
  - snap_valid pulses the cycle after cycle 4.
  - Return to the state the snapshot came from (IDLE or RUN).
- Requests arriving while busy=1 are dropped. No queuing.
- If irq asserts while busy, it is serviced on the first RUN cycle, since irq is level.
- tick_count wraps from all-ones to 0 with no flag.
- Reset asserted mid-operation aborts immediately to reset values; the bus is released the same cycle (asynchronous).

Test Plan:
1. Reset, then start with period_in=0x0000_0000_0000_0031, continuous=1 -> writes (2,0x0031),(3,0),(4,0),(5,0),(1,0x0007) on 5 consecutive cycles; running=1 on cycle 6.
2. With 1 running against the timer model, run 500 clocks -> irq every 50 clocks, each followed next cycle by write (0,0x0000) and a tick pulse; tick_count=10.
3. One-shot: start with period 9, continuous=0 -> control write 0x0005; after the first irq, ACK write occurs, state IDLE, running=0, tick_count=1, no further writes.
4. snap_req in RUN with the timer counter at 0x1234_5678_9ABC_DEF0 in the model -> write (6,0), reads of addr 6–9; snap_value=0x1234_5678_9ABC_DEF0; snap_valid pulses once, 7 cycles after the request; returns to RUN.
5. irq and stop asserted in the same RUN cycle -> ACK first (tick_count+1), then stop taken only if re-pulsed; a separate stop pulse -> write (1,0x0008), running=0.
6. Assert reset_n=0 during CFG cycle 2 -> chipselect=0, write_n=1, tick_count=0 immediately; after release state is IDLE and no further bus activity.
